sr_pulse_driver: RTL

- Upstream control stage for the sr_latch cell.
- Turns two asynchronous, possibly bouncing request inputs (set_in, reset_in) into clean, clock-aligned, fixed-width s/r pulses.
- Guarantees the latch never sees s=r=1, and guarantees a settle gap between consecutive pulses.
- Flags simultaneous conflicting requests.

---
 rtl/sr_pulse_driver_if.sv | 51 +++++
 rtl/sr_pulse_driver.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sr_pulse_driver_if.sv
// Request/command bundle between the request source and sr_pulse_driver.
// q_model is present only when SR_DRV_MIRROR_EN is defined.
interface sr_pulse_driver_if;
  logic set_in;
  logic reset_in;
  logic s;
  logic r;
  logic busy;
  logic conflict;
`ifdef SR_DRV_MIRROR_EN
  logic q_model;

  modport master (
    output set_in,
    output reset_in,
    input  s,
    input  r,
    input  busy,
    input  conflict,
    input  q_model
  );

  modport slave (
    input  set_in,
    input  reset_in,
    output s,
    output r,
    output busy,
    output conflict,
    output q_model
  );
`else
  modport master (
    output set_in,
    output reset_in,
    input  s,
    input  r,
    input  busy,
    input  conflict
  );

  modport slave (
    input  set_in,
    input  reset_in,
    output s,
    output r,
    output busy,
    output conflict
  );
`endif
endinterface

// File: rtl/sr_pulse_driver.sv
// Debounces set/reset requests and issues clean, gapped, never-overlapping s/r pulses for sr_latch.
// Optional SR_DRV_MIRROR_EN adds q_model and drops commands that would not change the latch.
module sr_pulse_driver #(
  parameter int unsigned DB_CYCLES    = 4,
  parameter int unsigned PULSE_W      = 2,
  parameter int unsigned GAP_W        = 1,
  parameter bit          PRIORITY_SET = 1'b1
) (
  input logic              clk,
  input logic              rst,
  sr_pulse_driver_if.slave bus
);

  // Input index 0 is the set path, 1 is the reset path.
  localparam int unsigned NumIn     = 2;
  localparam logic [7:0]  DbLimit   = 8'(DB_CYCLES);
  localparam logic [3:0]  PulseLast = 4'(PULSE_W - 1);
  localparam logic [3:0]  GapLast   = 4'(GAP_W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPulseS,
    StPulseR,
    StGap
  } state_e;

  logic [1:0] raw;
  logic [1:0] sync1_q, sync1_d;
  logic [1:0] sync2_q, sync2_d;
  logic [1:0] db_q, db_d;
  logic [1:0] req_q, req_d;
  logic [7:0] dbc_q [NumIn];
  logic [7:0] dbc_d [NumIn];

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pend_vld_q, pend_vld_d;
  logic       pend_set_q, pend_set_d;
  logic       s_q, s_d;
  logic       r_q, r_d;
  logic       conflict_q, conflict_d;

  logic       win_vld, win_set, win_drop;
  logic       disp_vld, disp_set, disp_drop;

  assign raw = {bus.reset_in, bus.set_in};

  // Synchronizers and debouncers; req_d flags a debounced rising transition.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    db_d    = db_q;
    req_d   = '0;
    for (int i = 0; i < NumIn; i++) begin
      dbc_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (dbc_q[i] + 8'd1 == DbLimit) begin
          db_d[i]  = ~db_q[i];
          req_d[i] = ~db_q[i];
        end else begin
          dbc_d[i] = dbc_q[i] + 8'd1;
        end
      end
    end
  end

  // Conflict resolution: the losing request of a simultaneous pair is discarded.
  assign win_vld  = |req_q;
  assign win_set  = (&req_q) ? PRIORITY_SET : req_q[0];

  // At the end of a gap a request arriving that same cycle is newer than the slot.
  assign disp_vld = win_vld | pend_vld_q;
  assign disp_set = win_vld ? win_set : pend_set_q;

`ifdef SR_DRV_MIRROR_EN
  logic q_model_q, q_model_d;

  assign win_drop    = (win_set == q_model_q);
  assign disp_drop   = (disp_set == q_model_q);
  assign bus.q_model = q_model_q;
`else
  assign win_drop  = 1'b0;
  assign disp_drop = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_vld_d = pend_vld_q;
    pend_set_d = pend_set_q;
`ifdef SR_DRV_MIRROR_EN
    q_model_d  = q_model_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (win_vld && !win_drop) begin
          state_d = win_set ? StPulseS : StPulseR;
          cnt_d   = '0;
        end
      end
      StPulseS, StPulseR: begin
        if (win_vld) begin
          pend_vld_d = 1'b1;
          pend_set_d = win_set;
        end
        if (cnt_q == PulseLast) begin
          state_d   = StGap;
          cnt_d     = '0;
`ifdef SR_DRV_MIRROR_EN
          q_model_d = (state_q == StPulseS);
`endif
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d      = '0;
          pend_vld_d = 1'b0;
          if (disp_vld && !disp_drop) begin
            state_d = disp_set ? StPulseS : StPulseR;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (win_vld) begin
            pend_vld_d = 1'b1;
            pend_set_d = win_set;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered decodes of the next state, so s and r can never overlap.
  always_comb begin
    s_d        = (state_d == StPulseS);
    r_d        = (state_d == StPulseR);
    conflict_d = &req_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_q       <= '0;
      req_q      <= '0;
      dbc_q      <= '{default: '0};
      state_q    <= StIdle;
      cnt_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_set_q <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
`ifdef SR_DRV_MIRROR_EN
      q_model_q  <= 1'b0;
`endif
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_q       <= db_d;
      req_q      <= req_d;
      dbc_q      <= dbc_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_vld_q <= pend_vld_d;
      pend_set_q <= pend_set_d;
      s_q        <= s_d;
      r_q        <= r_d;
      conflict_q <= conflict_d;
`ifdef SR_DRV_MIRROR_EN
      q_model_q  <= q_model_d;
`endif
    end
  end

  assign bus.s        = s_q;
  assign bus.r        = r_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.conflict = conflict_q;

endmodule
